// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared constants and helpers for the register write-back controller:
// load funct3 encodings, FSM states, and the register-zero constant.
package reg_writeback_ctrl_pkg;

   localparam int XLEN_DEF       = 32;
   localparam int LD_TIMEOUT_DEF = 255;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } ld_funct3_e;

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_LOAD_WAIT = 1'b1
   } wb_state_e;

   // True when a live (non-x0) pending destination matches either decode source.
   function automatic logic rd_hit(input logic [4:0] pend_rd,
                                   input logic [4:0] ra_a,
                                   input logic [4:0] ra_b);
      rd_hit = (pend_rd != REG_ZERO) && ((pend_rd == ra_a) || (pend_rd == ra_b));
   endfunction

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bus bundle between EX/MEM, the data cache, decode and the register file
// as seen by the write-back controller.
interface reg_writeback_ctrl_if
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            ld_issue;
   logic [4:0]      ld_rd;
   logic [2:0]      ld_funct3;
   logic [1:0]      ld_addr_lo;
   logic            mem_resp_valid;
   logic [XLEN-1:0] mem_resp_data;
   logic [4:0]      dec_raA;
   logic [4:0]      dec_raB;
   logic            rf_wen;
   logic [4:0]      rf_wa;
   logic [XLEN-1:0] rf_wd;
   logic            hazard_stall;
   logic            ld_busy;
   logic            ld_err;

   // Pipeline / cache / decode side that drives requests and observes the write stream.
   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
      output mem_resp_valid, mem_resp_data,
      output dec_raA, dec_raB,
      input  rf_wen, rf_wa, rf_wd, hazard_stall, ld_busy, ld_err
   );

   // Write-back controller side.
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
      input  mem_resp_valid, mem_resp_data,
      input  dec_raA, dec_raB,
      output rf_wen, rf_wa, rf_wd, hazard_stall, ld_busy, ld_err
   );
endinterface

// File: rtl/reg_writeback_ctrl_load_extend.sv
// Picks the addressed byte/halfword out of an aligned load word and
// sign- or zero-extends it to XLEN according to the load funct3.
module reg_writeback_ctrl_load_extend
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
)
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] word_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] byte_sh_s;
   logic [XLEN-1:0] half_sh_s;

   // Shift the addressed lane down to bit 0, then extend by load type.
   always_comb begin
      byte_sh_s = word_i >> {addr_lo_i, 3'b000};
      half_sh_s = word_i >> {addr_lo_i[1], 4'b0000};
      data_o    = word_i;
      case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){byte_sh_s[7]}}, byte_sh_s[7:0]};
         F3_LH:   data_o = {{(XLEN-16){half_sh_s[15]}}, half_sh_s[15:0]};
         F3_LW:   data_o = word_i;
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sh_s[7:0]};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sh_s[15:0]};
         default: data_o = word_i;   // unknown load type: write the raw word
      endcase
   end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port controller: merges single-cycle ALU results with
// the single outstanding load's response into one registered write stream,
// tracks the load destination for load-use stalls, and drops loads whose
// response never arrives.
module reg_writeback_ctrl
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int LD_TIMEOUT = LD_TIMEOUT_DEF
)
(
   input  logic                 clock,
   input  logic                 reset,
   reg_writeback_ctrl_if.slave  bus
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(LD_TIMEOUT);

   wb_state_e       state_q;
   logic [4:0]      pend_rd_q;
   logic [2:0]      pend_f3_q;
   logic [1:0]      pend_lo_q;
   logic [7:0]      cnt_q;
   logic            ld_err_q;

   logic            hold_valid_q, hold_valid_d;
   logic [4:0]      hold_rd_q,    hold_rd_d;
   logic [XLEN-1:0] hold_data_q,  hold_data_d;

   logic            rf_wen_q, rf_wen_d;
   logic [4:0]      rf_wa_q,  rf_wa_d;
   logic [XLEN-1:0] rf_wd_q,  rf_wd_d;

   logic            ld_busy_s;
   logic            mem_fire_s;
   logic            alu_live_s;
   logic [XLEN-1:0] ld_data_s;

   assign ld_busy_s  = (state_q == ST_LOAD_WAIT);
   // A response only counts while a load is outstanding; stray or post-reset responses are ignored.
   assign mem_fire_s = ld_busy_s & bus.mem_resp_valid;
   // ALU results to x0 are discarded outright and never occupy the holding register.
   assign alu_live_s = bus.alu_valid & (bus.alu_rd != REG_ZERO);

   reg_writeback_ctrl_load_extend #(.XLEN(XLEN)) u_load_extend (
      .funct3_i  (pend_f3_q),
      .addr_lo_i (pend_lo_q),
      .word_i    (bus.mem_resp_data),
      .data_o    (ld_data_s)
   );

   // Load tracking FSM: latch the load on issue, count wait cycles, finish on response or timeout.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pend_rd_q <= 5'd0;
         pend_f3_q <= 3'd0;
         pend_lo_q <= 2'd0;
         cnt_q     <= 8'd0;
         ld_err_q  <= 1'b0;
      end else begin
         ld_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.ld_issue) begin
                  state_q   <= ST_LOAD_WAIT;
                  pend_rd_q <= bus.ld_rd;
                  pend_f3_q <= bus.ld_funct3;
                  pend_lo_q <= bus.ld_addr_lo;
                  cnt_q     <= 8'd0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LOAD_WAIT: begin
               // A further ld_issue here is illegal and simply ignored.
               if (bus.mem_resp_valid) begin
                  state_q <= ST_IDLE;
               end else if (cnt_q == TIMEOUT_CNT) begin
                  state_q  <= ST_IDLE;
                  ld_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;   // stops at TIMEOUT_CNT, so it saturates
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Write-port arbitration: load response, then held ALU result, then fresh ALU result.
   always_comb begin
      rf_wen_d     = 1'b0;
      rf_wa_d      = rf_wa_q;
      rf_wd_d      = rf_wd_q;
      hold_valid_d = hold_valid_q;
      hold_rd_d    = hold_rd_q;
      hold_data_d  = hold_data_q;
      if (mem_fire_s) begin
         rf_wen_d = (pend_rd_q != REG_ZERO);
         rf_wa_d  = pend_rd_q;
         rf_wd_d  = ld_data_s;
         // The colliding ALU result waits one cycle in the holding register.
         if (!hold_valid_q && alu_live_s) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = bus.alu_rd;
            hold_data_d  = bus.alu_data;
         end else begin
            hold_valid_d = hold_valid_q;
         end
      end else if (hold_valid_q) begin
         rf_wen_d = 1'b1;
         rf_wa_d  = hold_rd_q;
         rf_wd_d  = hold_data_q;
         // Stall should prevent this, but a new result is queued rather than lost.
         if (alu_live_s) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = bus.alu_rd;
            hold_data_d  = bus.alu_data;
         end else begin
            hold_valid_d = 1'b0;
         end
      end else if (bus.alu_valid) begin
         rf_wen_d = alu_live_s;
         rf_wa_d  = bus.alu_rd;
         rf_wd_d  = bus.alu_data;
      end else begin
         rf_wen_d = 1'b0;
      end
   end

   // Register the write-port outputs and the holding register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rf_wen_q     <= 1'b0;
         rf_wa_q      <= 5'd0;
         rf_wd_q      <= '0;
         hold_valid_q <= 1'b0;
         hold_rd_q    <= 5'd0;
         hold_data_q  <= '0;
      end else begin
         rf_wen_q     <= rf_wen_d;
         rf_wa_q      <= rf_wa_d;
         rf_wd_q      <= rf_wd_d;
         hold_valid_q <= hold_valid_d;
         hold_rd_q    <= hold_rd_d;
         hold_data_q  <= hold_data_d;
      end
   end

   // The stall drops once the load leaves LOAD_WAIT; the register file bypass covers the write cycle.
   assign bus.hazard_stall = hold_valid_q |
                             (ld_busy_s & rd_hit(pend_rd_q, bus.dec_raA, bus.dec_raB));
   assign bus.ld_busy      = ld_busy_s;
   assign bus.ld_err       = ld_err_q;
   assign bus.rf_wen       = rf_wen_q;
   assign bus.rf_wa        = rf_wa_q;
   assign bus.rf_wd        = rf_wd_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: load-extension vector table,
// directed multi-cycle sequences, and randomized traffic against a
// queue-based reference model of the write stream.
module tb_reg_writeback_ctrl;

   localparam int LD_TIMEOUT = 255;

   logic clock;
   logic reset;

   reg_writeback_ctrl_if #(.XLEN(32)) bus ();

   reg_writeback_ctrl #(.XLEN(32), .LD_TIMEOUT(LD_TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t         m_q[$];       // results accepted but not yet written
   bit          m_pending;
   logic [4:0]  m_prd;
   logic [2:0]  m_pf3;
   logic [1:0]  m_plo;
   int          m_wait;
   bit          exp_wen;
   logic [4:0]  exp_wa;
   logic [31:0] exp_wd;
   bit          exp_err;

   function automatic logic [31:0] ref_ext(logic [2:0] f3, logic [1:0] lo, logic [31:0] w);
      int unsigned b;
      int unsigned h;
      b = (w >> (8 * lo)) & 32'h0000_00FF;
      h = (w >> (16 * (lo / 2))) & 32'h0000_FFFF;
      case (f3)
         3'b000:  return (b >= 128) ? b - 256 : b;
         3'b001:  return (h >= 32768) ? h - 65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic bit model_stall();
      bit hit;
      hit = m_pending && (m_prd != 5'd0) && (m_prd == bus.dec_raA || m_prd == bus.dec_raB);
      return (m_q.size() > 0) || hit;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pending = 1'b0;
      m_wait    = 0;
      exp_wen   = 1'b0;
      exp_wa    = 5'd0;
      exp_wd    = 32'd0;
      exp_err   = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently on the bus.
   task automatic model_step();
      wr_t w;
      exp_err = 1'b0;
      if (m_pending) begin
         if (bus.mem_resp_valid) begin
            w.rd   = m_prd;
            w.data = ref_ext(m_pf3, m_plo, bus.mem_resp_data);
            m_q.push_back(w);
            m_pending = 1'b0;
         end else if (m_wait == LD_TIMEOUT) begin
            m_pending = 1'b0;
            exp_err   = 1'b1;
         end else begin
            m_wait++;
         end
      end else if (bus.ld_issue) begin
         m_pending = 1'b1;
         m_prd     = bus.ld_rd;
         m_pf3     = bus.ld_funct3;
         m_plo     = bus.ld_addr_lo;
         m_wait    = 0;
      end
      if (bus.alu_valid && bus.alu_rd != 5'd0) begin
         w.rd   = bus.alu_rd;
         w.data = bus.alu_data;
         m_q.push_back(w);
      end
      if (m_q.size() > 0) begin
         w       = m_q.pop_front();
         exp_wen = (w.rd != 5'd0);
         exp_wa  = w.rd;
         exp_wd  = w.data;
      end else begin
         exp_wen = 1'b0;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.alu_valid      = 1'b0;
      bus.alu_rd         = 5'd0;
      bus.alu_data       = 32'd0;
      bus.ld_issue       = 1'b0;
      bus.ld_rd          = 5'd0;
      bus.ld_funct3      = 3'd0;
      bus.ld_addr_lo     = 2'd0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = 32'd0;
      bus.dec_raA        = 5'd0;
      bus.dec_raB        = 5'd0;
   endtask

   // Called 2 time units after a rising edge with inputs already driven:
   // check combinational outputs, clock once, check registered outputs.
   task automatic tick();
      #1;
      check("ld_busy", {31'd0, bus.ld_busy}, {31'd0, m_pending});
      check("hazard_stall", {31'd0, bus.hazard_stall}, {31'd0, model_stall()});
      model_step();
      @(posedge clock);
      #2;
      check("rf_wen", {31'd0, bus.rf_wen}, {31'd0, exp_wen});
      if (exp_wen) begin
         check("rf_wa", {27'd0, bus.rf_wa}, {27'd0, exp_wa});
         check("rf_wd", bus.rf_wd, exp_wd);
      end
      check("ld_err", {31'd0, bus.ld_err}, {31'd0, exp_err});
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_rf_wen"}, {31'd0, bus.rf_wen}, 32'd0);
      check({tag, "_rf_wa"},  {27'd0, bus.rf_wa},  32'd0);
      check({tag, "_rf_wd"},  bus.rf_wd,           32'd0);
      check({tag, "_ld_err"}, {31'd0, bus.ld_err}, 32'd0);
      check({tag, "_ld_busy"}, {31'd0, bus.ld_busy}, 32'd0);
      check({tag, "_stall"},  {31'd0, bus.hazard_stall}, 32'd0);
   endtask

   // ---------------- extension vector table ----------------
   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] word;
      logic [31:0] exp_wd;
   } ext_vec_t;

   ext_vec_t vecs[12];

   initial begin
      int n;

      vecs[0]  = '{3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80};
      vecs[1]  = '{3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080};
      vecs[2]  = '{3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
      vecs[3]  = '{3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001};
      vecs[4]  = '{3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[5]  = '{3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F};
      vecs[6]  = '{3'b000, 2'd3, 32'h8500_0000, 32'hFFFF_FF85};
      vecs[7]  = '{3'b001, 2'd0, 32'h1234_F00D, 32'hFFFF_F00D};
      vecs[8]  = '{3'b001, 2'd1, 32'h0000_7FFF, 32'h0000_7FFF};
      vecs[9]  = '{3'b011, 2'd0, 32'hCAFE_0001, 32'hCAFE_0001};
      vecs[10] = '{3'b100, 2'd1, 32'h0000_AB00, 32'h0000_00AB};
      vecs[11] = '{3'b110, 2'd3, 32'h1111_2222, 32'h1111_2222};

      // Reset state
      reset = 1'b0;
      idle_inputs();
      model_reset();
      #1;
      check_all_zero("reset");
      @(posedge clock);
      #2;
      reset = 1'b1;

      // 1: lone ALU write
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000_1234;
      tick();
      check("t1_wen", {31'd0, bus.rf_wen}, 32'd1);
      check("t1_wa", {27'd0, bus.rf_wa}, 32'd5);
      check("t1_wd", bus.rf_wd, 32'h0000_1234);
      idle_inputs();
      #1;
      check("t1_stall", {31'd0, bus.hazard_stall}, 32'd0);
      #0;

      // Table: load extraction and extension
      for (int i = 0; i < 12; i++) begin
         idle_inputs();
         bus.ld_issue = 1'b1; bus.ld_rd = 5'd4;
         bus.ld_funct3 = vecs[i].f3; bus.ld_addr_lo = vecs[i].lo;
         tick();
         idle_inputs();
         bus.mem_resp_valid = 1'b1; bus.mem_resp_data = vecs[i].word;
         tick();
         check($sformatf("vec%0d_wen", i), {31'd0, bus.rf_wen}, 32'd1);
         check($sformatf("vec%0d_wd", i), bus.rf_wd, vecs[i].exp_wd);
      end
      idle_inputs();
      tick();

      // 2: LB to x3 with a dependent decode; response on the 4th wait cycle
      bus.ld_issue = 1'b1; bus.ld_rd = 5'd3; bus.ld_funct3 = 3'b000; bus.ld_addr_lo = 2'd2;
      tick();
      idle_inputs();
      bus.dec_raA = 5'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_stall_wait", {31'd0, bus.hazard_stall}, 32'd1);
      end
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0080_0000;
      tick();
      check("t2_wd", bus.rf_wd, 32'hFFFF_FF80);
      bus.mem_resp_valid = 1'b0;
      #1;
      check("t2_stall_write", {31'd0, bus.hazard_stall}, 32'd0);
      check("t2_busy_write", {31'd0, bus.ld_busy}, 32'd0);
      #0;
      idle_inputs();
      tick();

      // 3: response and ALU collide; ALU result held one cycle
      bus.ld_issue = 1'b1; bus.ld_rd = 5'd3; bus.ld_funct3 = 3'b010;
      tick();
      idle_inputs();
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_0033;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h0000_00AA;
      tick();
      check("t3_first_wa", {27'd0, bus.rf_wa}, 32'd3);
      idle_inputs();
      #1;
      check("t3_stall_hold", {31'd0, bus.hazard_stall}, 32'd1);
      #0;
      tick();
      check("t3_second_wa", {27'd0, bus.rf_wa}, 32'd7);
      check("t3_second_wd", bus.rf_wd, 32'h0000_00AA);
      #1;
      check("t3_stall_clear", {31'd0, bus.hazard_stall}, 32'd0);
      #0;

      // 4: timeout on a load that never returns
      bus.ld_issue = 1'b1; bus.ld_rd = 5'd9; bus.ld_funct3 = 3'b010;
      tick();
      idle_inputs();
      n = 0;
      for (int i = 1; i <= 400; i++) begin
         tick();
         if (bus.ld_err) begin
            n = i;
            break;
         end
      end
      check("t4_err_cycle", n, LD_TIMEOUT + 1);
      #1;
      check("t4_busy_after", {31'd0, bus.ld_busy}, 32'd0);
      #0;
      tick();

      // 5: x0 destinations never write
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF_FFFF;
      tick();
      check("t5_alu_x0", {31'd0, bus.rf_wen}, 32'd0);
      idle_inputs();
      bus.ld_issue = 1'b1; bus.ld_rd = 5'd0; bus.ld_funct3 = 3'b010;
      tick();
      idle_inputs();
      tick();
      check("t5_busy_x0", {31'd0, bus.ld_busy}, 32'd1);
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h5555_5555;
      tick();
      check("t5_load_x0", {31'd0, bus.rf_wen}, 32'd0);
      idle_inputs();
      #1;
      check("t5_busy_clear", {31'd0, bus.ld_busy}, 32'd0);
      #0;

      // 6: reset during LOAD_WAIT, then a late response
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'h0000_0BEE;
      bus.ld_issue = 1'b1; bus.ld_rd = 5'd12; bus.ld_funct3 = 3'b010;
      tick();
      idle_inputs();
      bus.dec_raA = 5'd12;
      tick();
      reset = 1'b0;
      #1;
      check_all_zero("t6_reset");
      model_reset();
      @(posedge clock);
      #2;
      reset = 1'b1;
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h7777_7777;
      tick();
      check("t6_late_resp", {31'd0, bus.rf_wen}, 32'd0);
      idle_inputs();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         if (m_q.size() == 0 && $urandom_range(0, 1) == 1) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'($urandom_range(0, 7));
            bus.alu_data  = $urandom;
         end
         if ($urandom_range(0, 3) == 0) begin
            bus.ld_issue   = 1'b1;
            bus.ld_rd      = 5'($urandom_range(0, 7));
            bus.ld_funct3  = 3'($urandom_range(0, 7));
            bus.ld_addr_lo = 2'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 2) == 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = $urandom;
         end
         bus.dec_raA = 5'($urandom_range(0, 7));
         bus.dec_raB = 5'($urandom_range(0, 7));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
